// File: rtl/psum_drain_if.sv
// Bus bundle for psum_drain: skewed carry-save input row plus the drained-row
// valid/ready output. BW follows the PE psum width, ceillog2(SIZE)+16.
interface psum_drain_if #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned COLS = 16
);
  localparam int unsigned BW = $clog2(SIZE) + 16;

  logic                 in_valid;
  logic [COLS*BW-1:0]   psum0;
  logic [COLS*BW-1:0]   psum1;
  logic                 out_valid;
  logic                 out_ready;
  logic [COLS*BW-1:0]   out_data;

  modport master (
    output in_valid, psum0, psum1, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, psum0, psum1, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/psum_drain.sv
// Deskews per-column carry-save psum pairs, resolves them to signed sums and
// drains completed rows through a FIFO. Optional macro: PSUM_DRAIN_RELU_EN.
module psum_drain #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  psum_drain_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         busy
);
  localparam int unsigned BW = $clog2(SIZE) + 16;
  localparam int unsigned RW = COLS * BW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  // vsr[COLS-1] marks the row currently held in the adder register
  logic [COLS-1:0] vsr;
  logic [BW-1:0]   al0 [COLS];
  logic [BW-1:0]   al1 [COLS];
  logic [RW-1:0]   res;
  logic [RW-1:0]   sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsr <= '0;
    end else begin
      vsr <= (vsr << 1) | COLS'(bus.in_valid);
    end
  end

  // Column c arrives c cycles late, so it needs COLS-1-c registers to line up
  // with the last column, which is taken straight from the bus.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_live
      assign al0[c] = bus.psum0[c*BW +: BW];
      assign al1[c] = bus.psum1[c*BW +: BW];
    end else begin : g_dly
      localparam int unsigned N = COLS - 1 - c;
      logic [BW-1:0] d0 [N];
      logic [BW-1:0] d1 [N];

      always_ff @(posedge clk) begin
        d0[0] <= bus.psum0[c*BW +: BW];
        d1[0] <= bus.psum1[c*BW +: BW];
        for (int unsigned i = 1; i < N; i++) begin
          d0[i] <= d0[i-1];
          d1[i] <= d1[i-1];
        end
      end

      assign al0[c] = d0[N-1];
      assign al1[c] = d1[N-1];
    end
  end

  always_comb begin
    res = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      res[c*BW +: BW] = al0[c] + al1[c];
`ifdef PSUM_DRAIN_RELU_EN
      if (res[c*BW + BW - 1]) begin
        res[c*BW +: BW] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= res;
  end

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;

  assign push          = vsr[COLS-1];
  assign full          = (level == LW'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the row
  assign wr            = push && (!full || pop);
  assign bus.out_data  = bus.out_valid ? mem[rp] : '0;
  assign busy          = |vsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (wr && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr) begin
        level <= level - 1'b1;
      end
      if (push && !wr) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= sum_q;
    end
  end
endmodule
